fp_div_iterative: RTL and testbench

//  Parametrised sequential IEEE-754 divider: dividend / divisor, radix-2 restoring

---
 rtl/fp_div_iterative.sv | 227 ++++++++++++++++++++++
 tb/tb_fp_div_iterative.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_iterative.sv
// Sequential IEEE-754 divider: radix-2 restoring mantissa recurrence, round-to-nearest-even,
// flush-to-zero inputs, full special-case handling. One operation in flight.
module fp_div_iterative #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 data_valid,
  input  logic [EXP_W+MAN_W:0] dividend,
  input  logic [EXP_W+MAN_W:0] divisor,
  output logic                 busy,
  output logic                 data_ready,
  output logic [EXP_W+MAN_W:0] quotient_o,
  output logic                 divided_by_zero,
  output logic                 invalid,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int XLEN = 1 + EXP_W + MAN_W;
  localparam int QB   = MAN_W + 3;
  localparam int RW   = MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(QB);

  localparam logic [CW-1:0]        LAST_CNT  = CW'(QB - 1);
  localparam logic [CW-1:0]        CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0]     EXP_ONES  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]     EXP_ZERO  = {EXP_W{1'b0}};
  localparam logic [MAN_W-1:0]     MAN_ZERO  = {MAN_W{1'b0}};
  localparam logic [XLEN-1:0]      QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] BIAS_E    = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EW-1:0] EXP_MAX_E = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW-1:0] E_ONE     = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] E_ZERO    = {EW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t state_r, next_state_s;

  logic [EXP_W-1:0] exp_a_s, exp_b_s;
  logic [MAN_W-1:0] frac_a_s, frac_b_s;
  logic a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic sign_s, special_s, accept_s;
  logic [XLEN-1:0] spec_res_s;
  logic spec_inv_s, spec_dbz_s;

  logic [RW-1:0]          rem_r, diff_s;
  logic [MAN_W:0]         dvsr_r;
  logic [QB-1:0]          quo_r;
  logic signed [EW-1:0]   exp_r;
  logic                   sign_r;
  logic [CW-1:0]          cnt_r;
  logic                   ge_s;

  logic [MAN_W-1:0]       frac_pre_s;
  logic [MAN_W:0]         frac_sum_s;
  logic signed [EW-1:0]   exp_pre_s, exp_fin_s;
  logic                   guard_s, rnd_bit_s, sticky_s, inc_s;
  logic [XLEN-1:0]        rnd_res_s;
  logic                   rnd_ovf_s, rnd_unf_s;
  logic                   busy_s, ready_s;

  assign exp_a_s  = dividend[XLEN-2:MAN_W];
  assign exp_b_s  = divisor[XLEN-2:MAN_W];
  assign frac_a_s = dividend[MAN_W-1:0];
  assign frac_b_s = divisor[MAN_W-1:0];
  // Subnormals collapse to zero because only the exponent field is tested
  assign a_zero_s = (exp_a_s == EXP_ZERO);
  assign b_zero_s = (exp_b_s == EXP_ZERO);
  assign a_inf_s  = (exp_a_s == EXP_ONES) & (frac_a_s == MAN_ZERO);
  assign b_inf_s  = (exp_b_s == EXP_ONES) & (frac_b_s == MAN_ZERO);
  assign a_nan_s  = (exp_a_s == EXP_ONES) & (frac_a_s != MAN_ZERO);
  assign b_nan_s  = (exp_b_s == EXP_ONES) & (frac_b_s != MAN_ZERO);
  assign sign_s   = dividend[XLEN-1] ^ divisor[XLEN-1];
  assign special_s = a_zero_s | b_zero_s | a_inf_s | b_inf_s | a_nan_s | b_nan_s;
  assign accept_s  = (state_r == ST_IDLE) & data_valid;

  assign ge_s   = (rem_r >= {1'b0, dvsr_r});
  assign diff_s = rem_r - {1'b0, dvsr_r};

  // Special-operand result, resolved in priority order
  always_comb begin
    spec_res_s = {XLEN{1'b0}};
    spec_inv_s = 1'b0;
    spec_dbz_s = 1'b0;
    if (a_nan_s | b_nan_s | (a_zero_s & b_zero_s) | (a_inf_s & b_inf_s)) begin
      spec_res_s = QNAN;
      spec_inv_s = 1'b1;
    end else if (a_inf_s) begin
      spec_res_s = {sign_s, EXP_ONES, MAN_ZERO};
    end else if (b_inf_s | a_zero_s) begin
      spec_res_s = {sign_s, {(XLEN-1){1'b0}}};
    end else if (b_zero_s) begin
      spec_res_s = {sign_s, EXP_ONES, MAN_ZERO};
      spec_dbz_s = 1'b1;
    end else begin
      spec_res_s = {XLEN{1'b0}};
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (data_valid) next_state_s = special_s ? ST_DONE : ST_DIVIDE;
        else            next_state_s = ST_IDLE;
      end
      ST_DIVIDE: begin
        if (cnt_r == LAST_CNT) next_state_s = ST_ROUND;
        else                   next_state_s = ST_DIVIDE;
      end
      ST_ROUND: next_state_s = ST_DONE;
      ST_DONE:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // FSM output decode, registered below
  always_comb begin
    busy_s  = 1'b0;
    ready_s = 1'b0;
    case (next_state_s)
      ST_DIVIDE, ST_ROUND: busy_s  = 1'b1;
      ST_DONE:             ready_s = 1'b1;
      default: begin
        busy_s  = 1'b0;
        ready_s = 1'b0;
      end
    endcase
  end

  // Operand capture and restoring recurrence, one quotient bit per cycle
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rem_r  <= {RW{1'b0}};
      dvsr_r <= {(MAN_W+1){1'b0}};
      quo_r  <= {QB{1'b0}};
      exp_r  <= E_ZERO;
      sign_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else if (accept_s) begin
      rem_r  <= {1'b0, 1'b1, frac_a_s};
      dvsr_r <= {1'b1, frac_b_s};
      quo_r  <= {QB{1'b0}};
      exp_r  <= $signed({2'b00, exp_a_s}) - $signed({2'b00, exp_b_s}) + BIAS_E;
      sign_r <= sign_s;
      cnt_r  <= {CW{1'b0}};
    end else if (state_r == ST_DIVIDE) begin
      rem_r  <= ge_s ? {diff_s[RW-2:0], 1'b0} : {rem_r[RW-2:0], 1'b0};
      quo_r  <= {quo_r[QB-2:0], ge_s};
      cnt_r  <= cnt_r + CNT_ONE;
    end
  end

  // Normalise, round to nearest even, and range-check the exponent
  always_comb begin
    if (quo_r[QB-1]) begin
      frac_pre_s = quo_r[QB-2:2];
      guard_s    = quo_r[1];
      rnd_bit_s  = quo_r[0];
      exp_pre_s  = exp_r;
    end else begin
      frac_pre_s = quo_r[QB-3:1];
      guard_s    = quo_r[0];
      rnd_bit_s  = 1'b0;
      exp_pre_s  = exp_r - E_ONE;
    end
    sticky_s   = rnd_bit_s | (rem_r != {RW{1'b0}});
    inc_s      = guard_s & (sticky_s | frac_pre_s[0]);
    frac_sum_s = {1'b0, frac_pre_s} + {{MAN_W{1'b0}}, inc_s};
    if (frac_sum_s[MAN_W]) exp_fin_s = exp_pre_s + E_ONE;
    else                   exp_fin_s = exp_pre_s;
    rnd_ovf_s = 1'b0;
    rnd_unf_s = 1'b0;
    if (exp_fin_s >= EXP_MAX_E) begin
      rnd_res_s = {sign_r, EXP_ONES, MAN_ZERO};
      rnd_ovf_s = 1'b1;
    end else if (exp_fin_s <= E_ZERO) begin
      rnd_res_s = {sign_r, {(XLEN-1){1'b0}}};
      rnd_unf_s = 1'b1;
    end else begin
      rnd_res_s = {sign_r, exp_fin_s[EXP_W-1:0], frac_sum_s[MAN_W-1:0]};
    end
  end

  // Registered handshake, result and flags; flags clear on accept, hold after data_ready
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      busy            <= 1'b0;
      data_ready      <= 1'b0;
      quotient_o      <= {XLEN{1'b0}};
      divided_by_zero <= 1'b0;
      invalid         <= 1'b0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      busy       <= busy_s;
      data_ready <= ready_s;
      if (accept_s) begin
        divided_by_zero <= spec_dbz_s;
        invalid         <= spec_inv_s;
        overflow        <= 1'b0;
        underflow       <= 1'b0;
        if (special_s) quotient_o <= spec_res_s;
      end else if (state_r == ST_ROUND) begin
        quotient_o <= rnd_res_s;
        overflow   <= rnd_ovf_s;
        underflow  <= rnd_unf_s;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_iterative.sv
// Self-checking bench for fp_div_iterative (binary32 and binary64 instances) against an
// exact-integer reference divider with round-to-nearest-even.
module tb_fp_div_iterative;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv32 = 1'b0, dv64 = 1'b0;
  logic [31:0] a32 = 32'd0, b32 = 32'd0, q32;
  logic [63:0] a64 = 64'd0, b64 = 64'd0, q64;
  logic busy32, rdy32, dbz32, inv32, ovf32, unf32;
  logic busy64, rdy64, dbz64, inv64, ovf64, unf64;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp_div_iterative #(.EXP_W(8), .MAN_W(23)) dut32 (
    .CLK(clk), .rst_n(rst_n), .data_valid(dv32), .dividend(a32), .divisor(b32),
    .busy(busy32), .data_ready(rdy32), .quotient_o(q32), .divided_by_zero(dbz32),
    .invalid(inv32), .overflow(ovf32), .underflow(unf32));

  fp_div_iterative #(.EXP_W(11), .MAN_W(52)) dut64 (
    .CLK(clk), .rst_n(rst_n), .data_valid(dv64), .dividend(a64), .divisor(b64),
    .busy(busy64), .data_ready(rdy64), .quotient_o(q64), .divided_by_zero(dbz64),
    .invalid(inv64), .overflow(ovf64), .underflow(unf64));

  // Reference: exact integer quotient with remainder, then RNE by comparing the
  // discarded fraction against one half ulp. flg = {dbz, invalid, overflow, underflow}.
  function automatic void ref_div(input int ew, input int mw, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] res,
                                  output logic [3:0] flg, output int lat);
    int xl, bias, ea, eb, e;
    logic [63:0] ones, fmask, fa, fb, sgnv;
    logic sg, az, bz, ai, bi, an, bn;
    logic [127:0] ma, mb, q, r, keep, rest, half, lhs;
    xl = 1 + ew + mw;
    ones = (64'd1 << ew) - 64'd1;
    fmask = (64'd1 << mw) - 64'd1;
    bias = (1 << (ew - 1)) - 1;
    ea = int'((a >> mw) & ones);
    eb = int'((b >> mw) & ones);
    fa = a & fmask;
    fb = b & fmask;
    sg = a[xl-1] ^ b[xl-1];
    sgnv = {63'd0, sg} << (xl - 1);
    az = (ea == 0); bz = (eb == 0);
    ai = (ea == int'(ones)) && (fa == 64'd0);
    bi = (eb == int'(ones)) && (fb == 64'd0);
    an = (ea == int'(ones)) && (fa != 64'd0);
    bn = (eb == int'(ones)) && (fb != 64'd0);
    flg = 4'b0000;
    lat = (az || bz || ai || bi || an || bn) ? 1 : mw + 5;
    if (an || bn || (az && bz) || (ai && bi)) begin
      res = (ones << mw) | (64'd1 << (mw - 1));
      flg = 4'b0100;
    end else if (ai) begin
      res = sgnv | (ones << mw);
    end else if (bi || az) begin
      res = sgnv;
    end else if (bz) begin
      res = sgnv | (ones << mw);
      flg = 4'b1000;
    end else begin
      ma = {64'd0, fa | (64'd1 << mw)};
      mb = {64'd0, fb | (64'd1 << mw)};
      q = (ma << (mw + 3)) / mb;
      r = (ma << (mw + 3)) % mb;
      e = ea - eb + bias;
      if ((q >> (mw + 3)) != 128'd0) begin
        keep = q >> 3; rest = q & 128'd7; half = 128'd4;
      end else begin
        keep = q >> 2; rest = q & 128'd3; half = 128'd2; e = e - 1;
      end
      lhs = rest * mb + r;
      if (lhs > half * mb || (lhs == half * mb && keep[0])) keep = keep + 128'd1;
      if ((keep >> (mw + 1)) != 128'd0) begin
        keep = keep >> 1; e = e + 1;
      end
      if (e >= int'(ones)) begin
        res = sgnv | (ones << mw); flg = 4'b0010;
      end else if (e <= 0) begin
        res = sgnv; flg = 4'b0001;
      end else begin
        res = sgnv | (64'(e) << mw) | (keep[63:0] & fmask);
      end
    end
  endfunction

  function automatic logic [63:0] rnd_operand(input int ew, input int mw, input int lo, input int hi);
    logic [63:0] fr, sg, ex;
    fr = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
    sg = 64'($urandom_range(0, 1)) << (ew + mw);
    ex = 64'($urandom_range(hi, lo)) << mw;
    return sg | ex | fr;
  endfunction

  // Launch one operation, wait (bounded) for data_ready, then step one cycle past DONE.
  task automatic do_op(input bit wide, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output logic [3:0] flg, output int lat);
    if (wide) begin dv64 = 1'b1; a64 = a; b64 = b; end
    else      begin dv32 = 1'b1; a32 = a[31:0]; b32 = b[31:0]; end
    @(posedge clk); #1;
    dv32 = 1'b0; dv64 = 1'b0;
    a32 = $urandom; b32 = $urandom; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    lat = -1;
    res = 64'd0;
    flg = 4'b0000;
    for (int n = 1; n <= 100; n++) begin
      if ((wide ? rdy64 : rdy32) === 1'b1) begin lat = n; break; end
      @(posedge clk); #1;
    end
    if (wide) begin res = q64; flg = {dbz64, inv64, ovf64, unf64}; end
    else      begin res = {32'd0, q32}; flg = {dbz32, inv32, ovf32, unf32}; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({busy32, rdy32, q32, dbz32, inv32, ovf32, unf32} !== 38'd0)
      $display("FAIL reset32 got %h want 0", {busy32, rdy32, q32, dbz32, inv32, ovf32, unf32});
    else n_pass++;
    n_checks++;
    if ({busy64, rdy64, q64, dbz64, inv64, ovf64, unf64} !== 70'd0)
      $display("FAIL reset64 got %h want 0", {busy64, rdy64, q64, dbz64, inv64, ovf64, unf64});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed32();
    logic [63:0] res; logic [3:0] flg; int lat;
    do_op(1'b0, 64'h40C00000, 64'h40000000, res, flg, lat);
    n_checks++; if (res !== 64'h40400000) $display("FAIL div6_2 res got %h want 40400000", res); else n_pass++;
    n_checks++; if (flg !== 4'b0000) $display("FAIL div6_2 flags got %b want 0000", flg); else n_pass++;
    n_checks++; if (lat !== 28) $display("FAIL div6_2 latency got %0d want 28", lat); else n_pass++;
    n_checks++; if (rdy32 !== 1'b0) $display("FAIL ready_pulse got %b want 0", rdy32); else n_pass++;
    n_checks++; if (q32 !== 32'h40400000) $display("FAIL hold_q got %h want 40400000", q32); else n_pass++;
    do_op(1'b0, 64'h3F800000, 64'h40400000, res, flg, lat);
    n_checks++; if (res !== 64'h3EAAAAAB) $display("FAIL div1_3 res got %h want 3EAAAAAB", res); else n_pass++;
    n_checks++; if (flg !== 4'b0000) $display("FAIL div1_3 flags got %b want 0000", flg); else n_pass++;
    n_checks++; if (lat !== 28) $display("FAIL div1_3 latency got %0d want 28", lat); else n_pass++;
  endtask

  task automatic test_specials();
    logic [31:0] ta [10] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'hFF800000, 32'h40000000,
                             32'h7FC00001, 32'h00000001, 32'hC0400000, 32'h7F800000, 32'h3F800000};
    logic [31:0] tb [10] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h40000000, 32'h7F800000,
                             32'h3F800000, 32'h3F800000, 32'h00000000, 32'h80000000, 32'hFF800001};
    logic [31:0] tr [10] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h00000000,
                             32'h7FC00000, 32'h00000000, 32'hFF800000, 32'hFF800000, 32'h7FC00000};
    logic [3:0]  tf [10] = '{4'b1000, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                             4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0100};
    logic [63:0] res; logic [3:0] flg; int lat;
    for (int i = 0; i < 10; i++) begin
      do_op(1'b0, {32'd0, ta[i]}, {32'd0, tb[i]}, res, flg, lat);
      n_checks++;
      if (res[31:0] !== tr[i]) $display("FAIL special%0d res got %h want %h", i, res[31:0], tr[i]); else n_pass++;
      n_checks++;
      if (flg !== tf[i]) $display("FAIL special%0d flags got %b want %b", i, flg, tf[i]); else n_pass++;
      n_checks++;
      if (lat !== 1) $display("FAIL special%0d latency got %0d want 1", i, lat); else n_pass++;
    end
  endtask

  task automatic test_range();
    logic [63:0] res; logic [3:0] flg; int lat;
    do_op(1'b0, 64'h7F000000, 64'h00800000, res, flg, lat);
    n_checks++; if (res !== 64'h7F800000) $display("FAIL overflow res got %h want 7F800000", res); else n_pass++;
    n_checks++; if (flg !== 4'b0010) $display("FAIL overflow flags got %b want 0010", flg); else n_pass++;
    do_op(1'b0, 64'h00800000, 64'h4B000000, res, flg, lat);
    n_checks++; if (res !== 64'h0) $display("FAIL underflow res got %h want 0", res); else n_pass++;
    n_checks++; if (flg !== 4'b0001) $display("FAIL underflow flags got %b want 0001", flg); else n_pass++;
    n_checks++; if (lat !== 28) $display("FAIL underflow latency got %0d want 28", lat); else n_pass++;
  endtask

  task automatic test_random32();
    logic [63:0] a, b, res, eres; logic [3:0] flg, eflg; int lat, elat, kind;
    logic [63:0] spc [5] = '{64'h0, 64'h80000000, 64'h7F800000, 64'h7FA00000, 64'h00001234};
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(9, 0);
      a = rnd_operand(8, 23, (kind < 6) ? 100 : 1, (kind < 6) ? 154 : 254);
      b = rnd_operand(8, 23, (kind < 6) ? 100 : 1, (kind < 6) ? 154 : 254);
      if (kind == 8) a = spc[$urandom_range(4, 0)];
      if (kind == 9) b = spc[$urandom_range(4, 0)];
      ref_div(8, 23, a, b, eres, eflg, elat);
      do_op(1'b0, a, b, res, flg, lat);
      n_checks++;
      if (res !== eres) $display("FAIL rand32_%0d %h/%h res got %h want %h", i, a, b, res, eres); else n_pass++;
      n_checks++;
      if (flg !== eflg) $display("FAIL rand32_%0d flags got %b want %b", i, flg, eflg); else n_pass++;
      n_checks++;
      if (lat !== elat) $display("FAIL rand32_%0d latency got %0d want %0d", i, lat, elat); else n_pass++;
    end
  endtask

  task automatic test_wide();
    logic [63:0] a, b, res, eres; logic [3:0] flg, eflg; int lat, elat;
    do_op(1'b1, 64'h4018000000000000, 64'h4000000000000000, res, flg, lat);
    n_checks++; if (res !== 64'h4008000000000000) $display("FAIL w6_2 res got %h want 4008000000000000", res); else n_pass++;
    n_checks++; if (lat !== 57) $display("FAIL w6_2 latency got %0d want 57", lat); else n_pass++;
    n_checks++; if (flg !== 4'b0000) $display("FAIL w6_2 flags got %b want 0000", flg); else n_pass++;
    do_op(1'b1, 64'h3FF0000000000000, 64'h4008000000000000, res, flg, lat);
    n_checks++; if (res !== 64'h3FD5555555555555) $display("FAIL w1_3 res got %h want 3FD5555555555555", res); else n_pass++;
    n_checks++; if (lat !== 57) $display("FAIL w1_3 latency got %0d want 57", lat); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      a = rnd_operand(11, 52, 1000, 1046);
      b = rnd_operand(11, 52, 1000, 1046);
      ref_div(11, 52, a, b, eres, eflg, elat);
      do_op(1'b1, a, b, res, flg, lat);
      n_checks++;
      if (res !== eres) $display("FAIL rand64_%0d %h/%h res got %h want %h", i, a, b, res, eres); else n_pass++;
      n_checks++;
      if ({flg, lat} !== {eflg, elat}) $display("FAIL rand64_%0d flags/lat got %b/%0d want %b/%0d", i, flg, lat, eflg, elat); else n_pass++;
    end
  endtask

  task automatic test_busy_drop();
    int c, extra;
    dv32 = 1'b1; a32 = 32'h40C00000; b32 = 32'h40000000;
    @(posedge clk); #1;
    dv32 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    dv32 = 1'b1; a32 = 32'h3F800000; b32 = 32'h40400000;
    n_checks++; if (busy32 !== 1'b1) $display("FAIL drop_busy5 got %b want 1", busy32); else n_pass++;
    @(posedge clk); #1;
    dv32 = 1'b0;
    n_checks++; if (busy32 !== 1'b1) $display("FAIL drop_busy6 got %b want 1", busy32); else n_pass++;
    c = 6;
    while (c < 100 && rdy32 !== 1'b1) begin @(posedge clk); #1; c++; end
    n_checks++; if (c !== 28) $display("FAIL drop_latency got %0d want 28", c); else n_pass++;
    n_checks++; if (q32 !== 32'h40400000) $display("FAIL drop_res got %h want 40400000", q32); else n_pass++;
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (rdy32 === 1'b1 || busy32 === 1'b1) extra++; end
    n_checks++; if (extra !== 0) $display("FAIL drop_no_queue got %0d want 0", extra); else n_pass++;
  endtask

  task automatic test_abort();
    logic [63:0] res; logic [3:0] flg; int lat, seen;
    dv32 = 1'b1; a32 = 32'h40C00000; b32 = 32'h40000000;
    @(posedge clk); #1;
    dv32 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy32, rdy32, q32, dbz32, inv32, ovf32, unf32} !== 38'd0)
      $display("FAIL abort_outputs got %h want 0", {busy32, rdy32, q32, dbz32, inv32, ovf32, unf32});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (rdy32 === 1'b1) seen++; end
    n_checks++; if (seen !== 0) $display("FAIL abort_no_ready got %0d want 0", seen); else n_pass++;
    do_op(1'b0, 64'h40C00000, 64'h40000000, res, flg, lat);
    n_checks++; if (res !== 64'h40400000) $display("FAIL abort_next got %h want 40400000", res); else n_pass++;
    n_checks++; if (lat !== 28) $display("FAIL abort_next_latency got %0d want 28", lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; logic [3:0] flg; int lat, c;
    do_op(1'b0, 64'hBF800000, 64'h80000000, res, flg, lat);
    n_checks++; if (res !== 64'h7F800000) $display("FAIL b2b_dbz res got %h want 7F800000", res); else n_pass++;
    n_checks++; if (flg !== 4'b1000) $display("FAIL b2b_dbz flags got %b want 1000", flg); else n_pass++;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if ({q32, dbz32} !== {32'h7F800000, 1'b1}) $display("FAIL b2b_hold got %h/%b want 7F800000/1", q32, dbz32);
    else n_pass++;
    dv32 = 1'b1; a32 = 32'h40C00000; b32 = 32'hC0000000;
    @(posedge clk); #1;
    dv32 = 1'b0;
    n_checks++;
    if ({busy32, dbz32} !== 2'b10) $display("FAIL b2b_clear got %b want 10", {busy32, dbz32}); else n_pass++;
    c = 1;
    while (c < 100 && rdy32 !== 1'b1) begin @(posedge clk); #1; c++; end
    n_checks++; if (q32 !== 32'hC0400000) $display("FAIL b2b_res got %h want C0400000", q32); else n_pass++;
    n_checks++; if (c !== 28) $display("FAIL b2b_latency got %0d want 28", c); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed32();
    test_specials();
    test_range();
    test_random32();
    test_wide();
    test_busy_drop();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
